// File: rtl/sensor_conditioner_if.sv
// Sample/threshold inputs and conditioned outputs of the sensor conditioner.
// master = producer of samples and thresholds, slave = the conditioner itself.
interface sensor_conditioner_if;
    logic [7:0] m_sample;
    logic       m_valid;
    logic [7:0] l_sample;
    logic       l_valid;
    logic [7:0] m_thresh_1;
    logic [7:0] m_thresh_2;
    logic [7:0] l_dawn;
    logic [7:0] l_day;
    logic       m_dry_1;
    logic       m_dry_2;
    logic [1:0] l_phase;
    logic [7:0] m_avg;
    logic [7:0] l_avg;
    logic       m_upd;
    logic       l_upd;

    modport master (
        output m_sample, m_valid, l_sample, l_valid,
               m_thresh_1, m_thresh_2, l_dawn, l_day,
        input  m_dry_1, m_dry_2, l_phase, m_avg, l_avg, m_upd, l_upd
    );

    modport slave (
        input  m_sample, m_valid, l_sample, l_valid,
               m_thresh_1, m_thresh_2, l_dawn, l_day,
        output m_dry_1, m_dry_2, l_phase, m_avg, l_avg, m_upd, l_upd
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Boxcar averaging of moisture/light ADC samples, hysteretic dryness flags
// and a day-phase classifier feeding the irrigation controller.

module sc_boxcar #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_sample,
    input  logic       i_valid,
    output logic       o_done,
    output logic [7:0] o_avg
);
    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_sum;
    logic          w_last;

    // Sum of a full window always fits in 8+AVG_LOG2 bits, so no overflow.
    assign w_sum  = r_acc + AW'(i_sample);
    assign w_last = (r_cnt == CW'((1 << AVG_LOG2) - 1));
    assign o_done = i_valid && w_last;
    assign o_avg  = 8'(w_sum >> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

module sensor_conditioner #(
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_conditioner_if.slave  bus
);
    typedef enum logic [1:0] {NIGHT = 2'b00, DAWN = 2'b01, DAY = 2'b10, DUSK = 2'b11} phase_t;

    logic [1:0][7:0] w_samp;
    logic [1:0][7:0] w_avg;
    logic [1:0]      w_vld;
    logic [1:0]      w_done;

    // Channel 0 = moisture, channel 1 = light.
    assign w_samp = {bus.l_sample, bus.m_sample};
    assign w_vld  = {bus.l_valid, bus.m_valid};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_ch
            sc_boxcar #(.AVG_LOG2(AVG_LOG2)) u_avg (
                .clk      (clk),
                .rst      (rst),
                .i_sample (w_samp[g]),
                .i_valid  (w_vld[g]),
                .o_done   (w_done[g]),
                .o_avg    (w_avg[g])
            );
        end
    endgenerate

    logic       r_m_dry_1, r_m_dry_2, r_m_upd, r_l_upd;
    logic [7:0] r_m_avg, r_l_avg;
    phase_t     r_phase, w_phase_nxt;

    // 9-bit sums: a threshold near 255 plus HYST cannot wrap, so the flag sticks.
    logic w_m_clr_1, w_m_clr_2;
    assign w_m_clr_1 = {1'b0, w_avg[0]} > ({1'b0, bus.m_thresh_1} + 9'(HYST));
    assign w_m_clr_2 = {1'b0, w_avg[0]} > ({1'b0, bus.m_thresh_2} + 9'(HYST));

    logic [8:0] w_l_hi;
    logic       w_ge_dawn, w_ge_day, w_lt_dawn, w_lt_day;
    assign w_l_hi    = {1'b0, w_avg[1]} + 9'(HYST);
    assign w_ge_dawn = w_avg[1] >= bus.l_dawn;
    assign w_ge_day  = w_avg[1] >= bus.l_day;
    assign w_lt_dawn = w_l_hi < {1'b0, bus.l_dawn};
    assign w_lt_day  = w_l_hi < {1'b0, bus.l_day};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_dry_1 <= 1'b0;
            r_m_dry_2 <= 1'b0;
            r_m_avg   <= '0;
            r_l_avg   <= '0;
            r_m_upd   <= 1'b0;
            r_l_upd   <= 1'b0;
        end else begin
            r_m_upd <= w_done[0];
            r_l_upd <= w_done[1];
            if (w_done[0]) begin
                r_m_avg <= w_avg[0];
                if (w_avg[0] <= bus.m_thresh_1)  r_m_dry_1 <= 1'b1;
                else if (w_m_clr_1)              r_m_dry_1 <= 1'b0;
                if (w_avg[0] <= bus.m_thresh_2)  r_m_dry_2 <= 1'b1;
                else if (w_m_clr_2)              r_m_dry_2 <= 1'b0;
            end
            if (w_done[1]) r_l_avg <= w_avg[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_phase <= NIGHT;
        else     r_phase <= w_phase_nxt;
    end

    // At most one step per window so DAWN is always visible between NIGHT and DAY.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_done[1]) begin
            case (r_phase)
                NIGHT: if (w_ge_dawn) w_phase_nxt = DAWN;
                DAWN: begin
                    if (w_ge_day)       w_phase_nxt = DAY;
                    else if (w_lt_dawn) w_phase_nxt = NIGHT;
                end
                DAY:   if (w_lt_day) w_phase_nxt = DUSK;
                DUSK: begin
                    if (w_lt_dawn)     w_phase_nxt = NIGHT;
                    else if (w_ge_day) w_phase_nxt = DAY;
                end
                default: w_phase_nxt = NIGHT;
            endcase
        end
    end

    assign bus.m_dry_1 = r_m_dry_1;
    assign bus.m_dry_2 = r_m_dry_2;
    assign bus.m_avg   = r_m_avg;
    assign bus.l_avg   = r_l_avg;
    assign bus.m_upd   = r_m_upd;
    assign bus.l_upd   = r_l_upd;
    assign bus.l_phase = r_phase;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomized and directed stimulus against a window-level reference model;
// expected updates are queued and checked by an independent monitor.
module tb_sensor_conditioner;
    localparam int N = 2;
    localparam int H = 8;
    localparam int W = 1 << N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sensor_conditioner_if bus();

    sensor_conditioner #(.AVG_LOG2(N), .HYST(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {int avg; int d1; int d2;} mexp_t;
    typedef struct {int avg; int ph;} lexp_t;

    mexp_t mq[$];
    lexp_t lq[$];
    mexp_t me;
    lexp_t le;
    int    mbuf[$];
    int    lbuf[$];
    int    md1 = 0, md2 = 0, lph = 0;
    int    checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: average whole windows, then apply threshold/phase rules.
    task automatic model_edge();
        int s, a;
        if (bus.m_valid) begin
            mbuf.push_back(int'(bus.m_sample));
            if (mbuf.size() == W) begin
                s = 0;
                foreach (mbuf[i]) s += mbuf[i];
                a = s / W;
                if (a <= int'(bus.m_thresh_1)) md1 = 1;
                else if (a > int'(bus.m_thresh_1) + H) md1 = 0;
                if (a <= int'(bus.m_thresh_2)) md2 = 1;
                else if (a > int'(bus.m_thresh_2) + H) md2 = 0;
                mq.push_back('{a, md1, md2});
                mbuf.delete();
            end
        end
        if (bus.l_valid) begin
            lbuf.push_back(int'(bus.l_sample));
            if (lbuf.size() == W) begin
                s = 0;
                foreach (lbuf[i]) s += lbuf[i];
                a = s / W;
                case (lph)
                    0: if (a >= int'(bus.l_dawn)) lph = 1;
                    1: if (a >= int'(bus.l_day)) lph = 2;
                       else if (a + H < int'(bus.l_dawn)) lph = 0;
                    2: if (a + H < int'(bus.l_day)) lph = 3;
                    default: if (a + H < int'(bus.l_dawn)) lph = 0;
                             else if (a >= int'(bus.l_day)) lph = 2;
                endcase
                lq.push_back('{a, lph});
                lbuf.delete();
            end
        end
    endtask

    task automatic step(input bit mv, input int ms, input bit lv, input int ls);
        bus.m_valid  = mv;
        bus.m_sample = ms[7:0];
        bus.l_valid  = lv;
        bus.l_sample = ls[7:0];
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic reset_dut();
        step(0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_m_dry_1", int'(bus.m_dry_1), 0);
        chk("rst_m_dry_2", int'(bus.m_dry_2), 0);
        chk("rst_l_phase", int'(bus.l_phase), 0);
        chk("rst_m_avg",   int'(bus.m_avg), 0);
        chk("rst_l_avg",   int'(bus.l_avg), 0);
        chk("rst_m_upd",   int'(bus.m_upd), 0);
        chk("rst_l_upd",   int'(bus.l_upd), 0);
        rst = 1'b0;
        mbuf.delete(); lbuf.delete(); mq.delete(); lq.delete();
        md1 = 0; md2 = 0; lph = 0;
    endtask

    task automatic mwin(input int a, input int b, input int c, input int d);
        step(1, a, 0, 0); step(1, b, 0, 0); step(1, c, 0, 0); step(1, d, 0, 0);
    endtask

    task automatic lwin(input int v);
        for (int i = 0; i < W; i++) step(0, 0, 1, v);
    endtask

    // Monitor: every queued window must appear exactly one cycle after completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (mq.size() > 0) begin
                me = mq.pop_front();
                chk("m_upd",   int'(bus.m_upd), 1);
                chk("m_avg",   int'(bus.m_avg), me.avg);
                chk("m_dry_1", int'(bus.m_dry_1), me.d1);
                chk("m_dry_2", int'(bus.m_dry_2), me.d2);
            end else if (bus.m_upd !== 1'b0) begin
                chk("m_upd_spurious", int'(bus.m_upd), 0);
            end
            if (lq.size() > 0) begin
                le = lq.pop_front();
                chk("l_upd",   int'(bus.l_upd), 1);
                chk("l_avg",   int'(bus.l_avg), le.avg);
                chk("l_phase", int'(bus.l_phase), le.ph);
            end else if (bus.l_upd !== 1'b0) begin
                chk("l_upd_spurious", int'(bus.l_upd), 0);
            end
        end
    end

    initial begin
        int mbase, lbase, t1, t2, d;
        bus.m_valid = 0; bus.m_sample = 0; bus.l_valid = 0; bus.l_sample = 0;
        bus.m_thresh_1 = 8'd120; bus.m_thresh_2 = 8'd60;
        bus.l_dawn = 8'd50; bus.l_day = 8'd150;
        reset_dut();

        mwin(200, 200, 200, 200);
        chk("dir_avg200", int'(bus.m_avg), 200);
        chk("dir_avg200_d1", int'(bus.m_dry_1), 0);
        mwin(100, 100, 110, 110);
        chk("dir_avg105", int'(bus.m_avg), 105);
        chk("dir_avg105_d1", int'(bus.m_dry_1), 1);
        chk("dir_avg105_d2", int'(bus.m_dry_2), 0);
        mwin(125, 125, 125, 125);
        chk("dir_avg125_d1_hold", int'(bus.m_dry_1), 1);
        mwin(129, 129, 129, 129);
        chk("dir_avg129_d1_clr", int'(bus.m_dry_1), 0);
        mwin(60, 60, 60, 60);
        chk("dir_avg60_d1", int'(bus.m_dry_1), 1);
        chk("dir_avg60_d2", int'(bus.m_dry_2), 1);
        mwin(68, 68, 68, 68);
        chk("dir_avg68_d2_hold", int'(bus.m_dry_2), 1);
        mwin(69, 69, 69, 69);
        chk("dir_avg69_d2_clr", int'(bus.m_dry_2), 0);
        chk("dir_avg69_d1", int'(bus.m_dry_1), 1);

        lwin(20);  chk("dir_ph_20",  int'(bus.l_phase), 0);
        lwin(200); chk("dir_ph_200a", int'(bus.l_phase), 1);
        lwin(200); chk("dir_ph_200b", int'(bus.l_phase), 2);
        lwin(130); chk("dir_ph_130", int'(bus.l_phase), 3);
        lwin(40);  chk("dir_ph_40",  int'(bus.l_phase), 0);

        step(1, 8, 0, 0);  step(0, 0, 0, 0); step(1, 8, 0, 0);  step(0, 0, 0, 0);
        step(1, 12, 0, 0); step(0, 0, 0, 0); step(1, 12, 0, 0);
        chk("dir_gap_avg", int'(bus.m_avg), 10);

        step(1, 50, 0, 0); step(1, 50, 0, 0);
        reset_dut();
        mwin(40, 40, 40, 40);
        chk("dir_rst_window_avg", int'(bus.m_avg), 40);

        for (int i = 0; i < W; i++) step(1, 90, 1, 90);
        chk("dir_both_m_upd", int'(bus.m_upd), 1);
        chk("dir_both_l_upd", int'(bus.l_upd), 1);

        mwin(1, 1, 1, 2);
        chk("dir_trunc_avg", int'(bus.m_avg), 1);

        mbase = 100; lbase = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) begin
                t1 = $urandom_range(255, 0);
                t2 = $urandom_range(t1, 0);
                d  = $urandom_range(200, 0);
                bus.m_thresh_1 = t1[7:0];
                bus.m_thresh_2 = t2[7:0];
                bus.l_dawn     = d[7:0];
                t1 = $urandom_range(255, d + 1);
                bus.l_day      = t1[7:0];
            end
            if (c % 37 == 0) begin
                mbase = $urandom_range(224, 0);
                lbase = $urandom_range(224, 0);
            end
            if ($urandom_range(599, 0) == 0) reset_dut();
            step($urandom_range(1, 0) == 1, mbase + $urandom_range(31, 0),
                 $urandom_range(1, 0) == 1, lbase + $urandom_range(31, 0));
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
